// File: rtl/ntt_stage_sequencer_if.sv
// Handshake and loop-index bundle between the NTT stage sequencer and its neighbours.
// master: the sequencer. slave: the control/address-generator side.
interface ntt_stage_sequencer_if;
  logic       start;
  logic       stall;
  logic       busy;
  logic       valid;
  logic [3:0] p;
  logic [4:0] k;
  logic [4:0] j;
  logic [4:0] i;
  logic       stage_last;
  logic       done;

  modport master (
    input  start, stall,
    output busy, valid, p, k, j, i, stage_last, done
  );

  modport slave (
    output start, stall,
    input  busy, valid, p, k, j, i, stage_last, done
  );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Loop-index sequencer for a 128-point mixed-radix NTT: 4 stages of 32 butterflies,
// with a programmable drain gap between stages and stall-safe replay of the frozen slot.
module ntt_stage_sequencer #(
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned NUM_BFLY  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  ntt_stage_sequencer_if.master        seq
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [4:0] BFLY_LAST  = 5'(NUM_BFLY - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

  state_t     state, state_n;
  logic [1:0] stage, stage_n;
  logic [4:0] bfly, bfly_n;
  logic [3:0] drain_cnt, drain_cnt_n;
  // live: the slot held in state/stage/bfly/drain_cnt was presented this cycle.
  // A slot frozen by stall is not live and is replayed once stall drops.
  logic       live, live_n;
  logic       consumed;

  logic       busy_q, valid_q, last_q, done_q;
  logic [3:0] p_q;
  logic [4:0] k_q, j_q, i_q;
  logic [4:0] k_n, j_n, i_n;

  assign consumed = live || (state == IDLE);

  // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    stage_n     = stage;
    bfly_n      = bfly;
    drain_cnt_n = drain_cnt;
    live_n      = !seq.stall;
    unique case (state)
      IDLE: begin
        live_n = 1'b1;
        if (seq.start) begin
          state_n = RUN;
          stage_n = 2'd0;
          bfly_n  = 5'd0;
        end
      end
      RUN: if (consumed) begin
        if (bfly == BFLY_LAST) begin
          state_n     = (stage == 2'd3) ? DONE : DRAIN;
          drain_cnt_n = 4'd0;
        end else begin
          bfly_n = bfly + 5'd1;
        end
      end
      DRAIN: if (consumed) begin
        if (drain_cnt == DRAIN_LAST) begin
          state_n     = RUN;
          stage_n     = stage + 2'd1;
          bfly_n      = 5'd0;
          drain_cnt_n = 4'd0;
        end else begin
          drain_cnt_n = drain_cnt + 4'd1;
        end
      end
      DONE: if (consumed) begin
        state_n = IDLE;
        stage_n = 2'd0;
        bfly_n  = 5'd0;
      end
    endcase
  end

  // Linear butterfly count splits into j (low 2p bits) and k (the rest) for p<3.
  always_comb begin
    k_n = 5'd0;
    j_n = 5'd0;
    i_n = 5'd0;
    if (stage_n == 2'd3) begin
      i_n = bfly_n;
    end else begin
      j_n = bfly_n & ((5'd1 << {stage_n, 1'b0}) - 5'd1);
      k_n = bfly_n >> {stage_n, 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      stage     <= 2'd0;
      bfly      <= 5'd0;
      drain_cnt <= 4'd0;
      live      <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      p_q       <= 4'd0;
      k_q       <= 5'd0;
      j_q       <= 5'd0;
      i_q       <= 5'd0;
    end else begin
      state     <= state_n;
      stage     <= stage_n;
      bfly      <= bfly_n;
      drain_cnt <= drain_cnt_n;
      live      <= live_n;
      busy_q    <= (state_n != IDLE);
      valid_q   <= live_n && (state_n == RUN);
      last_q    <= live_n && (state_n == RUN) && (bfly_n == BFLY_LAST);
      done_q    <= live_n && (state_n == DONE);
      p_q       <= {2'b00, stage_n};
      k_q       <= k_n;
      j_q       <= j_n;
      i_q       <= i_n;
    end
  end

  assign seq.busy       = busy_q;
  assign seq.valid      = valid_q;
  assign seq.stage_last = last_q;
  assign seq.done       = done_q;
  assign seq.p          = p_q;
  assign seq.k          = k_q;
  assign seq.j          = j_q;
  assign seq.i          = i_q;

endmodule

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
- Drives the loop indices (p, k, j, i) that the butterfly address generator consumes. Covers one full 128-point mixed-radix transform.
- The transform has 4 stages (p = 0..3) of 32 butterflies each.
- Between stages the sequencer inserts a drain gap so the butterfly pipeline empties before the next stage reads memory.
- Sits between the top-level NTT control (start/done) and the address generator / butterfly datapath.

Parameters:
- DRAIN_CYC, 4, idle cycles inserted between consecutive stages (1..15).
- NUM_BFLY, 32, butterflies per stage. Fixed for the 128-point transform; not meant to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a transform; ignored while busy.
- stall  input  1  freezes all sequencer state while high.
- busy  output  1  high from the cycle after start is accepted until the cycle after done.
- valid  output  1  p/k/j/i form a legal butterfly index this cycle.
- p  output  4  current stage, 0..3.
- k  output  5  group index (stages 0..2).
- j  output  5  intra-group index (stages 0..2).
- i  output  5  linear butterfly index (stage 3).
- stage_last  output  1  high with valid on the final butterfly of a stage.
- done  output  1  one-cycle pulse after the final butterfly of stage 3.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy, valid, stage_last and done = 0; p, k, j and i = 0; drain counter = 0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → RUN next cycle with p=0 and k=j=i=0. busy=1 and valid=1 in that same first RUN cycle.
  - start while not in IDLE has no effect.
- RUN, index order per stage; each of the 32 butterflies emits exactly once, in this order:
  - Stage p<3: j counts 0..4^p−1 fastest, then k counts 0..(32/4^p)−1.
  - p=0: j=0, k=0..31.
  - p=1: j=0..3, k=0..7.
  - p=2: j=0..15, k=0..1.
  - p=3: i=0..31, with k=j=0.
  - Indices not used in the current stage are held at 0.
- stage_last = valid on the 32nd butterfly of a stage. Next-cycle transition:
  - p<3 → DRAIN.
  - p=3 → DONE.
- DRAIN:
  - valid=0; indices are held at their last values.
  - The drain counter counts DRAIN_CYC cycles.
  - On the last drain cycle: p increments, k=j=i=0, and the state goes to RUN. valid=1 the following cycle.
- DONE:
  - done=1 and valid=0 for one cycle; busy remains 1 in that cycle.
  - Next cycle: IDLE, busy=0, and p, k, j, i return to 0.
- stall=1 in RUN, DRAIN or DONE:
  - State, counters and indices are frozen.
  - valid, stage_last and done are forced to 0.
  - The frozen butterfly re-emits when stall drops, so no index is skipped or duplicated.
  - A done pulse pending under stall is emitted once after release.
- stall in IDLE: start is still accepted, and the stall is applied from the next cycle.
- Timing, no stalls, DRAIN_CYC=4, start high in cycle 0:

| Event | Cycles |
|---|---|
| p=0 valid | 1..32 |
| drain | 33..36 |
| p=1 valid | 37..68 |
| drain | 69..72 |
| p=2 valid | 73..104 |
| drain | 105..108 |
| p=3 valid | 109..140 |
| done | 141 |
| busy=0 | from 142 |

  - General total: 4·32 + 3·DRAIN_CYC + 1 busy cycles.
- rst asserted mid-transform aborts immediately to reset values; no done is emitted.
- start in the same cycle as the DONE→IDLE transition is ignored. A new transform needs start while the state is IDLE.

Test Plan:
- Reset, then start pulse with no stall → 128 valid cycles; p sequence 0,1,2,3. done exactly once in cycle 141; busy low from cycle 142.
- Index check per stage:
  - p=1, 6th valid cycle → k=1, j=1.
  - p=2, 17th valid cycle → k=1, j=0.
  - p=3, last valid cycle → i=31, stage_last=1.
- stall=1 for 3 cycles at p=2, k=0, j=7 → valid low for 3 cycles, then resumes at k=0, j=7. done is delayed by exactly 3 cycles (cycle 144).
- start re-pulsed in cycles 10 and 141 → ignored; one transform only, and busy does not extend.
- rst low in cycle 50 (p=1) → all outputs 0 asynchronously. A subsequent start restarts at p=0, k=0, j=0.
- DRAIN_CYC=1 build → drain gaps are 1 cycle; done in cycle 132.
